mbus_tx_channel_arbiter: RTL and testbench

//  N-channel TX front end for an MBus regular node: N local requesters share one node TX_* port.

---
 rtl/mbus_tx_channel_arbiter_if.sv | 45 ++++
 rtl/mbus_tx_channel_arbiter.sv | 243 ++++++++++++++++++++++++
 tb/tb_mbus_tx_channel_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mbus_tx_channel_arbiter_if.sv
// Bundle between N local TX requesters, the channel arbiter and one MBus node TX port.
// Handshake semantics (4-phase, every signal level-sensitive):
//   CH_TX_REQ[c] rises with ADDR/DATA/PEND/PRIORITY stable -> CH_TX_ACK[c] rises -> REQ falls -> ACK falls.
//   Node side mirrors this with TX_REQ/TX_ACK. Results are held as TX_SUCC/TX_FAIL until
//   TX_RESP_ACK rises, then both sides return to zero. CH_TX_SUCC/FAIL vs CH_TX_RESP_ACK work the same way.
interface mbus_tx_channel_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [NUM_CH*ADDR_W-1:0] CH_TX_ADDR;
  logic [NUM_CH*DATA_W-1:0] CH_TX_DATA;
  logic [NUM_CH-1:0]        CH_TX_PEND;
  logic [NUM_CH-1:0]        CH_TX_REQ;
  logic [NUM_CH-1:0]        CH_TX_PRIORITY;
  logic [NUM_CH-1:0]        CH_TX_ACK;
  logic [NUM_CH-1:0]        CH_TX_SUCC;
  logic [NUM_CH-1:0]        CH_TX_FAIL;
  logic [NUM_CH-1:0]        CH_TX_RESP_ACK;
  logic [ADDR_W-1:0]        TX_ADDR;
  logic [DATA_W-1:0]        TX_DATA;
  logic                     TX_PEND;
  logic                     TX_REQ;
  logic                     PRIORITY;
  logic                     TX_ACK;
  logic                     TX_SUCC;
  logic                     TX_FAIL;
  logic                     TX_RESP_ACK;

  // master: the arbiter itself
  modport master (
    input  CH_TX_ADDR, CH_TX_DATA, CH_TX_PEND, CH_TX_REQ, CH_TX_PRIORITY, CH_TX_RESP_ACK,
    input  TX_ACK, TX_SUCC, TX_FAIL,
    output CH_TX_ACK, CH_TX_SUCC, CH_TX_FAIL,
    output TX_ADDR, TX_DATA, TX_PEND, TX_REQ, PRIORITY, TX_RESP_ACK
  );

  // slave: the surrounding clients plus node
  modport slave (
    output CH_TX_ADDR, CH_TX_DATA, CH_TX_PEND, CH_TX_REQ, CH_TX_PRIORITY, CH_TX_RESP_ACK,
    output TX_ACK, TX_SUCC, TX_FAIL,
    input  CH_TX_ACK, CH_TX_SUCC, CH_TX_FAIL,
    input  TX_ADDR, TX_DATA, TX_PEND, TX_REQ, PRIORITY, TX_RESP_ACK
  );
endinterface

// File: rtl/mbus_tx_channel_arbiter.sv
// Shares one MBus node TX port among NUM_CH requesters: per-message priority/round-robin
// arbitration, lock for multi-word (PEND) messages, and result routing to the owning channel.
module mbus_tx_channel_arbiter #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  localparam int GW = $clog2(NUM_CH)
) (
  input  logic                     CLKIN,
  input  logic                     RESET,
  mbus_tx_channel_arbiter_if.master bus,
  output logic [2:0]               dbg_state_o,
  output logic [GW-1:0]            dbg_grant_o,
  output logic [GW-1:0]            dbg_rr_ptr_o
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_ACKW = 3'd2;
  localparam logic [2:0] S_LOCK = 3'd3;
  localparam logic [2:0] S_RSLT = 3'd4;
  localparam logic [2:0] S_RESP = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  localparam logic [GW:0]   NCH     = (GW+1)'(NUM_CH);
  localparam logic [GW-1:0] LAST_CH = GW'(NUM_CH - 1);

  logic [2:0]        state_q, state_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [GW-1:0]     rr_ptr_q, rr_ptr_d;
  logic              launch_q, launch_d;
  logic [ADDR_W-1:0] tx_addr_q, tx_addr_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_pend_q, tx_pend_d;
  logic              tx_req_q, tx_req_d;
  logic              priority_q, priority_d;
  logic              tx_resp_ack_q, tx_resp_ack_d;
  logic [NUM_CH-1:0] ch_ack_q, ch_ack_d;
  logic [NUM_CH-1:0] ch_succ_q, ch_succ_d;
  logic [NUM_CH-1:0] ch_fail_q, ch_fail_d;

  logic [ADDR_W-1:0] ch_addr [NUM_CH];
  logic [DATA_W-1:0] ch_data [NUM_CH];
  logic [NUM_CH-1:0] prio_req;
  logic [NUM_CH-1:0] cand;
  logic [GW-1:0]     win_idx;
  logic [NUM_CH-1:0] gsel;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_unpack
    assign ch_addr[c] = bus.CH_TX_ADDR[c*ADDR_W +: ADDR_W];
    assign ch_data[c] = bus.CH_TX_DATA[c*DATA_W +: DATA_W];
  end

  // First set bit of 'set' at or after 'ptr', wrapping at NUM_CH.
  function automatic logic [GW-1:0] rr_pick(input logic [NUM_CH-1:0] set,
                                            input logic [GW-1:0] ptr);
    logic [GW-1:0] pick;
    logic          found;
    logic [GW:0]   idx;
    pick  = '0;
    found = 1'b0;
    for (int off = 0; off < NUM_CH; off++) begin
      idx = {1'b0, ptr} + (GW+1)'(off);
      if (idx >= NCH) idx = idx - NCH;
      if (!found && set[idx[GW-1:0]]) begin
        found = 1'b1;
        pick  = idx[GW-1:0];
      end
    end
    return pick;
  endfunction

  // High-priority requesters form the candidate set when any exist; rr_ptr is shared by both classes.
  always_comb begin
    prio_req = bus.CH_TX_REQ & bus.CH_TX_PRIORITY;
    cand     = (|prio_req) ? prio_req : bus.CH_TX_REQ;
    win_idx  = rr_pick(cand, rr_ptr_q);
  end

  always_comb begin
    gsel          = '0;
    gsel[grant_q] = 1'b1;
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    launch_d      = launch_q;
    tx_addr_d     = tx_addr_q;
    tx_data_d     = tx_data_q;
    tx_pend_d     = tx_pend_q;
    tx_req_d      = tx_req_q;
    priority_d    = priority_q;
    tx_resp_ack_d = tx_resp_ack_q;
    ch_ack_d      = ch_ack_q;
    ch_succ_d     = ch_succ_q;
    ch_fail_d     = ch_fail_q;

    case (state_q)
      S_IDLE: begin
        // Winner's word is latched first; TX_REQ follows one cycle later so TX_* is stable at the node.
        if (launch_q) begin
          tx_req_d = 1'b1;
          launch_d = 1'b0;
          state_d  = S_REQ;
        end else if (|bus.CH_TX_REQ) begin
          grant_d    = win_idx;
          tx_addr_d  = ch_addr[win_idx];
          tx_data_d  = ch_data[win_idx];
          tx_pend_d  = bus.CH_TX_PEND[win_idx];
          priority_d = bus.CH_TX_PRIORITY[win_idx];
          launch_d   = 1'b1;
        end
      end

      S_REQ: begin
        if (bus.TX_FAIL) begin
          tx_req_d  = 1'b0;
          ch_ack_d  = '0;
          ch_fail_d = gsel;
          state_d   = S_RESP;
        end else if (bus.TX_ACK) begin
          tx_req_d = 1'b0;
          ch_ack_d = gsel;
          state_d  = S_ACKW;
        end
      end

      S_ACKW: begin
        if (bus.TX_FAIL) begin
          tx_req_d  = 1'b0;
          ch_ack_d  = '0;
          ch_fail_d = gsel;
          state_d   = S_RESP;
        end else if (!bus.CH_TX_REQ[grant_q] && !bus.TX_ACK) begin
          ch_ack_d = '0;
          state_d  = tx_pend_q ? S_LOCK : S_RSLT;
        end
      end

      S_LOCK: begin
        // Mid-message: only the owning channel may continue.
        if (bus.TX_FAIL) begin
          tx_req_d  = 1'b0;
          ch_ack_d  = '0;
          ch_fail_d = gsel;
          state_d   = S_RESP;
        end else if (bus.CH_TX_REQ[grant_q]) begin
          tx_addr_d  = ch_addr[grant_q];
          tx_data_d  = ch_data[grant_q];
          tx_pend_d  = bus.CH_TX_PEND[grant_q];
          priority_d = bus.CH_TX_PRIORITY[grant_q];
          tx_req_d   = 1'b1;
          state_d    = S_REQ;
        end
      end

      S_RSLT: begin
        if (bus.TX_FAIL) begin
          ch_fail_d = gsel;
          state_d   = S_RESP;
        end else if (bus.TX_SUCC) begin
          ch_succ_d = gsel;
          state_d   = S_RESP;
        end
      end

      S_RESP: begin
        if (bus.CH_TX_RESP_ACK[grant_q]) begin
          tx_resp_ack_d = 1'b1;
        end else if (tx_resp_ack_q && !bus.TX_SUCC && !bus.TX_FAIL) begin
          ch_succ_d     = '0;
          ch_fail_d     = '0;
          tx_resp_ack_d = 1'b0;
          state_d       = S_DONE;
        end
      end

      S_DONE: begin
        rr_ptr_d = (grant_q == LAST_CH) ? '0 : grant_q + 1'b1;
        state_d  = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLKIN or posedge RESET) begin
    if (RESET) begin
      state_q       <= S_IDLE;
      grant_q       <= '0;
      rr_ptr_q      <= '0;
      launch_q      <= 1'b0;
      tx_addr_q     <= '0;
      tx_data_q     <= '0;
      tx_pend_q     <= 1'b0;
      tx_req_q      <= 1'b0;
      priority_q    <= 1'b0;
      tx_resp_ack_q <= 1'b0;
      ch_ack_q      <= '0;
      ch_succ_q     <= '0;
      ch_fail_q     <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      rr_ptr_q      <= rr_ptr_d;
      launch_q      <= launch_d;
      tx_addr_q     <= tx_addr_d;
      tx_data_q     <= tx_data_d;
      tx_pend_q     <= tx_pend_d;
      tx_req_q      <= tx_req_d;
      priority_q    <= priority_d;
      tx_resp_ack_q <= tx_resp_ack_d;
      ch_ack_q      <= ch_ack_d;
      ch_succ_q     <= ch_succ_d;
      ch_fail_q     <= ch_fail_d;
    end
  end

  assign bus.TX_ADDR     = tx_addr_q;
  assign bus.TX_DATA     = tx_data_q;
  assign bus.TX_PEND     = tx_pend_q;
  assign bus.TX_REQ      = tx_req_q;
  assign bus.PRIORITY    = priority_q;
  assign bus.TX_RESP_ACK = tx_resp_ack_q;
  assign bus.CH_TX_ACK   = ch_ack_q;
  assign bus.CH_TX_SUCC  = ch_succ_q;
  assign bus.CH_TX_FAIL  = ch_fail_q;

  assign dbg_state_o  = state_q;
  assign dbg_grant_o  = grant_q;
  assign dbg_rr_ptr_o = rr_ptr_q;

  // Channel-side indications never overlap: one owner, one phase at a time.
  a_ch_onehot0: assert property (@(posedge CLKIN) disable iff (RESET)
    $onehot0(ch_ack_q | ch_succ_q | ch_fail_q));
  a_no_req_with_ack: assert property (@(posedge CLKIN) disable iff (RESET)
    !(tx_req_q && (|ch_ack_q)));

endmodule

// File: tb/tb_mbus_tx_channel_arbiter.sv
// Directed bench for mbus_tx_channel_arbiter: single word, round-robin, priority, lock,
// abort and mid-message reset, with hand-computed expectations.
module tb_mbus_tx_channel_arbiter;
  localparam int NUM_CH = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic       clk;
  logic       rst;
  logic [2:0] dbg_state;
  logic [1:0] dbg_grant;
  logic [1:0] dbg_rr_ptr;

  int n_checks = 0;
  int n_pass   = 0;
  logic [1:0] exp_q[$];

  mbus_tx_channel_arbiter_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mbus_tx_channel_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLKIN        (clk),
    .RESET        (rst),
    .bus          (bus),
    .dbg_state_o  (dbg_state),
    .dbg_grant_o  (dbg_grant),
    .dbg_rr_ptr_o (dbg_rr_ptr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // driver tasks
  task automatic clear_inputs();
    bus.CH_TX_ADDR     = '0;
    bus.CH_TX_DATA     = '0;
    bus.CH_TX_PEND     = '0;
    bus.CH_TX_REQ      = '0;
    bus.CH_TX_PRIORITY = '0;
    bus.CH_TX_RESP_ACK = '0;
    bus.TX_ACK         = 1'b0;
    bus.TX_SUCC        = 1'b0;
    bus.TX_FAIL        = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic drive_ch(input int c, input logic [31:0] addr, input logic [31:0] data,
                          input logic pend, input logic prio);
    bus.CH_TX_ADDR[c*ADDR_W +: ADDR_W] = addr;
    bus.CH_TX_DATA[c*DATA_W +: DATA_W] = data;
    bus.CH_TX_PEND[c]                  = pend;
    bus.CH_TX_PRIORITY[c]              = prio;
    bus.CH_TX_REQ[c]                   = 1'b1;
  endtask

  task automatic wait_tx_req(input string tag);
    int n;
    n = 0;
    while (bus.TX_REQ !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (bus.TX_REQ !== 1'b1) check({tag, " tx_req timeout"}, 64'd0, 64'd1);
  endtask

  // One word: node sees the word, ACKs; channel sees CH_TX_ACK and completes 4-phase.
  task automatic xfer_word(input string tag, input int c, input logic [31:0] addr,
                           input logic [31:0] data, input logic pend, input logic prio);
    wait_tx_req(tag);
    check({tag, " tx_addr"}, bus.TX_ADDR, addr);
    check({tag, " tx_data"}, bus.TX_DATA, data);
    check({tag, " tx_pend"}, bus.TX_PEND, pend);
    check({tag, " priority"}, bus.PRIORITY, prio);
    bus.TX_ACK = 1'b1;
    tick();
    check({tag, " ch_ack"}, bus.CH_TX_ACK, 64'(1) << c);
    check({tag, " tx_req drop"}, bus.TX_REQ, 1'b0);
    bus.CH_TX_REQ[c] = 1'b0;
    bus.TX_ACK       = 1'b0;
    tick();
    check({tag, " ch_ack clear"}, bus.CH_TX_ACK, 64'd0);
  endtask

  task automatic respond(input string tag, input int c);
    bus.CH_TX_RESP_ACK[c] = 1'b1;
    tick();
    check({tag, " tx_resp_ack"}, bus.TX_RESP_ACK, 1'b1);
    bus.TX_SUCC           = 1'b0;
    bus.TX_FAIL           = 1'b0;
    bus.CH_TX_RESP_ACK[c] = 1'b0;
    tick();
    check({tag, " resp clear"}, {bus.CH_TX_SUCC, bus.CH_TX_FAIL, bus.TX_RESP_ACK}, 64'd0);
    tick();
  endtask

  task automatic finish_msg(input string tag, input int c, input logic succ, input logic fail);
    logic [63:0] exp_s;
    logic [63:0] exp_f;
    exp_s = (succ && !fail) ? (64'(1) << c) : 64'd0;
    exp_f = fail ? (64'(1) << c) : 64'd0;
    bus.TX_SUCC = succ;
    bus.TX_FAIL = fail;
    tick();
    check({tag, " ch_succ"}, bus.CH_TX_SUCC, exp_s);
    check({tag, " ch_fail"}, bus.CH_TX_FAIL, exp_f);
    respond(tag, c);
  endtask

  initial begin
    int c;
    clear_inputs();
    rst = 1'b0;

    // Reset state
    do_reset();
    check("rst outs", {bus.CH_TX_ACK, bus.CH_TX_SUCC, bus.CH_TX_FAIL, bus.TX_REQ,
                       bus.TX_PEND, bus.PRIORITY, bus.TX_RESP_ACK}, 64'd0);
    check("rst tx_addr", bus.TX_ADDR, 64'd0);
    check("rst tx_data", bus.TX_DATA, 64'd0);
    check("rst state", dbg_state, 3'd0);
    check("rst rr_ptr", dbg_rr_ptr, 2'd0);

    // 1: single word from ch2, 2-clock launch latency
    drive_ch(2, 32'h0000_00A5, 32'h1234_5678, 1'b0, 1'b0);
    tick();
    check("t1 tx_req lat1", bus.TX_REQ, 1'b0);
    tick();
    check("t1 tx_req lat2", bus.TX_REQ, 1'b1);
    xfer_word("t1", 2, 32'h0000_00A5, 32'h1234_5678, 1'b0, 1'b0);
    finish_msg("t1", 2, 1'b1, 1'b0);
    check("t1 rr_ptr", dbg_rr_ptr, 2'd3);
    check("t1 idle", dbg_state, 3'd0);

    // 2: round-robin with all four channels requesting
    do_reset();
    for (int i = 0; i < NUM_CH; i++) drive_ch(i, 32'h100 + i, 32'hD0 + i, 1'b0, 1'b0);
    for (int m = 0; m < 8; m++) exp_q.push_back(2'(m % NUM_CH));
    for (int m = 0; m < 8; m++) begin
      c = int'(exp_q.pop_front());
      xfer_word("t2 rr", c, 32'h100 + c, 32'hD0 + c, 1'b0, 1'b0);
      finish_msg("t2 rr", c, 1'b1, 1'b0);
      if (m < 4) drive_ch(c, 32'h100 + c, 32'hD0 + c, 1'b0, 1'b0);
    end
    check("t2 rr_ptr wrap", dbg_rr_ptr, 2'd0);

    // 3: priority overrides round-robin; also SUCC+FAIL together reports FAIL
    drive_ch(0, 32'hA0, 32'hB0, 1'b0, 1'b0);
    drive_ch(3, 32'hA3, 32'hB3, 1'b0, 1'b1);
    xfer_word("t3 prio", 3, 32'hA3, 32'hB3, 1'b0, 1'b1);
    finish_msg("t3 prio", 3, 1'b1, 1'b0);
    xfer_word("t3 low", 0, 32'hA0, 32'hB0, 1'b0, 1'b0);
    finish_msg("t3 both", 0, 1'b1, 1'b1);

    // 4: ch1 three-word message holds the lock while ch0 waits
    drive_ch(0, 32'hC0, 32'hE0, 1'b0, 1'b0);
    drive_ch(1, 32'hC1, 32'hE1, 1'b1, 1'b0);
    xfer_word("t4 w1", 1, 32'hC1, 32'hE1, 1'b1, 1'b0);
    tick();
    tick();
    check("t4 lock tx_req", bus.TX_REQ, 1'b0);
    check("t4 lock state", dbg_state, 3'd3);
    drive_ch(1, 32'hC1, 32'hE2, 1'b1, 1'b0);
    xfer_word("t4 w2", 1, 32'hC1, 32'hE2, 1'b1, 1'b0);
    drive_ch(1, 32'hC1, 32'hE3, 1'b0, 1'b0);
    xfer_word("t4 w3", 1, 32'hC1, 32'hE3, 1'b0, 1'b0);
    finish_msg("t4 ch1", 1, 1'b1, 1'b0);
    xfer_word("t4 ch0", 0, 32'hC0, 32'hE0, 1'b0, 1'b0);
    finish_msg("t4 ch0", 0, 1'b1, 1'b0);

    // 5: node abort in LOCK after word 2 of 3
    drive_ch(1, 32'hF1, 32'h11, 1'b1, 1'b0);
    xfer_word("t5 w1", 1, 32'hF1, 32'h11, 1'b1, 1'b0);
    drive_ch(1, 32'hF1, 32'h22, 1'b1, 1'b0);
    xfer_word("t5 w2", 1, 32'hF1, 32'h22, 1'b1, 1'b0);
    bus.TX_FAIL = 1'b1;
    tick();
    check("t5 ch_fail", bus.CH_TX_FAIL, 4'b0010);
    check("t5 ch_succ", bus.CH_TX_SUCC, 4'b0000);
    check("t5 tx_req", bus.TX_REQ, 1'b0);
    drive_ch(1, 32'hF1, 32'h33, 1'b0, 1'b0);
    tick();
    tick();
    check("t5 w3 blocked", bus.TX_REQ, 1'b0);
    bus.CH_TX_REQ[1] = 1'b0;
    respond("t5", 1);
    tick();
    tick();
    check("t5 w3 never sent", bus.TX_REQ, 1'b0);
    bus.TX_SUCC = 1'b1;
    tick();
    check("t5 succ in idle", bus.CH_TX_SUCC, 4'b0000);
    bus.TX_SUCC = 1'b0;
    check("t5 rr_ptr", dbg_rr_ptr, 2'd2);

    // 6: reset pulsed in RESP
    drive_ch(2, 32'h52, 32'h62, 1'b0, 1'b0);
    xfer_word("t6", 2, 32'h52, 32'h62, 1'b0, 1'b0);
    bus.TX_SUCC = 1'b1;
    tick();
    bus.CH_TX_RESP_ACK[2] = 1'b1;
    tick();
    check("t6 pre-rst resp_ack", bus.TX_RESP_ACK, 1'b1);
    rst = 1'b1;
    #1;
    check("t6 rst outs", {bus.CH_TX_ACK, bus.CH_TX_SUCC, bus.CH_TX_FAIL, bus.TX_REQ,
                          bus.TX_PEND, bus.PRIORITY, bus.TX_RESP_ACK}, 64'd0);
    check("t6 rst state", dbg_state, 3'd0);
    check("t6 rst rr_ptr", dbg_rr_ptr, 2'd0);
    clear_inputs();
    tick();
    rst = 1'b0;
    tick();
    drive_ch(3, 32'h73, 32'h83, 1'b0, 1'b0);
    drive_ch(0, 32'h70, 32'h80, 1'b0, 1'b0);
    xfer_word("t6 ch0", 0, 32'h70, 32'h80, 1'b0, 1'b0);
    finish_msg("t6 ch0", 0, 1'b1, 1'b0);
    xfer_word("t6 ch3", 3, 32'h73, 32'h83, 1'b0, 1'b0);
    finish_msg("t6 ch3", 3, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
